// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan-code sequence decoder (E0/F0/E1 prefixes) feeding a small event queue.
// Latency: one CLK from the accepting RX_VALID to EV_VALID; EV_READY pops the head, a full queue drops and flags OVERFLOW.
module ps2_key_event_ctrl #(
  parameter int FIFO_DEPTH    = 4,
  parameter int TIMEOUT_TICKS = 4000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       TICK,
  input  logic       RX_VALID,
  input  logic       RX_ERR,
  input  logic [7:0] RX_CODE,
  input  logic       EV_READY,
  input  logic       CLR_STATUS,
  output logic       EV_VALID,
  output logic [7:0] EV_CODE,
  output logic       EV_EXT,
  output logic       EV_REL,
  output logic       OVERFLOW,
  output logic [7:0] ERR_CNT,
  output logic       BUSY
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_TICKS);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_PAUSE} state_t;

  state_t          state_q, state_d;
  logic            ext_q, ext_d;
  logic [2:0]      remain_q, remain_d;
  logic [TW-1:0]   to_q;
  logic            to_hit;
  logic            push;
  logic [9:0]      push_dat;
  logic            err_inc;

  logic [9:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     cnt_q;
  logic            full, pop, wr_en, drop;
  logic [9:0]      head;

  logic [7:0]      err_q;
  logic            ovf_q;

  // A received byte always takes priority over a timeout landing in the same cycle.
  assign to_hit = (state_q != S_IDLE) && (to_q == TO_MAX);

  always_comb begin
    state_d  = state_q;
    ext_d    = ext_q;
    remain_d = remain_q;
    push     = 1'b0;
    push_dat = {RX_CODE, 2'b00};
    err_inc  = 1'b0;
    if (RX_VALID) begin
      if (RX_ERR) begin
        state_d = S_IDLE;
        err_inc = 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (RX_CODE == 8'hE0) begin
              state_d = S_EXT;
            end else if (RX_CODE == 8'hF0) begin
              state_d = S_BRK;
              ext_d   = 1'b0;
            end else if (RX_CODE == 8'hE1) begin
              state_d  = S_PAUSE;
              remain_d = 3'd7;
            end else if (RX_CODE == 8'h00 || RX_CODE == 8'hFF) begin
              err_inc = 1'b1;
            end else begin
              push = 1'b1;
            end
          end
          S_EXT: begin
            if (RX_CODE == 8'hF0) begin
              state_d = S_BRK;
              ext_d   = 1'b1;
            end else if (RX_CODE == 8'hE0) begin
              state_d = S_EXT;
            end else if (RX_CODE == 8'hE1) begin
              state_d = S_IDLE;
              err_inc = 1'b1;
            end else begin
              push     = 1'b1;
              push_dat = {RX_CODE, 2'b10};
              state_d  = S_IDLE;
            end
          end
          S_BRK: begin
            state_d = S_IDLE;
            if (RX_CODE == 8'hE0 || RX_CODE == 8'hF0 || RX_CODE == 8'hE1) begin
              err_inc = 1'b1;
            end else begin
              push     = 1'b1;
              push_dat = {RX_CODE, ext_q, 1'b1};
            end
          end
          S_PAUSE: begin
            // Pause payload is fixed length; its content is never inspected.
            remain_d = remain_q - 3'd1;
            if (remain_q == 3'd1) begin
              push     = 1'b1;
              push_dat = {8'hE1, 2'b00};
              state_d  = S_IDLE;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end else if (to_hit) begin
      state_d = S_IDLE;
      err_inc = 1'b1;
    end
    if (state_d == S_IDLE) begin
      ext_d    = 1'b0;
      remain_d = 3'd0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      ext_q    <= 1'b0;
      remain_q <= 3'd0;
      to_q     <= '0;
    end else begin
      state_q  <= state_d;
      ext_q    <= ext_d;
      remain_q <= remain_d;
      if (state_d == S_IDLE || RX_VALID)
        to_q <= '0;
      else if (TICK && to_q != TO_MAX)
        to_q <= to_q + 1'b1;
    end
  end

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign full  = (cnt_q == FULL_CNT);
  assign pop   = EV_VALID && EV_READY;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge CLK) begin
    if (wr_en)
      mem[wptr_q] <= push_dat;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en)
        wptr_q <= wptr_q + 1'b1;
      if (pop)
        rptr_q <= rptr_q + 1'b1;
      if (wr_en && !pop)
        cnt_q <= cnt_q + 1'b1;
      else if (!wr_en && pop)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      err_q <= 8'd0;
      ovf_q <= 1'b0;
    end else begin
      if (CLR_STATUS)
        err_q <= {7'd0, err_inc};
      else if (err_inc && err_q != 8'hFF)
        err_q <= err_q + 8'd1;
      if (CLR_STATUS)
        ovf_q <= drop;
      else if (drop)
        ovf_q <= 1'b1;
    end
  end

  assign head     = mem[rptr_q];
  assign EV_VALID = (cnt_q != '0);
  assign EV_CODE  = EV_VALID ? head[9:2] : 8'd0;
  assign EV_EXT   = EV_VALID && head[1];
  assign EV_REL   = EV_VALID && head[0];
  assign OVERFLOW = ovf_q;
  assign ERR_CNT  = err_q;
  assign BUSY     = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl: drives on falling CLK, checks on falling CLK.
module tb_ps2_key_event_ctrl;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       TICK = 1'b0;
  logic       RX_VALID = 1'b0;
  logic       RX_ERR = 1'b0;
  logic [7:0] RX_CODE = 8'h00;
  logic       EV_READY = 1'b0;
  logic       CLR_STATUS = 1'b0;
  logic       EV_VALID;
  logic [7:0] EV_CODE;
  logic       EV_EXT;
  logic       EV_REL;
  logic       OVERFLOW;
  logic [7:0] ERR_CNT;
  logic       BUSY;

  int passed = 0;
  int total = 0;

  ps2_key_event_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_TICKS(4000)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .TICK(TICK), .RX_VALID(RX_VALID), .RX_ERR(RX_ERR),
    .RX_CODE(RX_CODE), .EV_READY(EV_READY), .CLR_STATUS(CLR_STATUS), .EV_VALID(EV_VALID),
    .EV_CODE(EV_CODE), .EV_EXT(EV_EXT), .EV_REL(EV_REL), .OVERFLOW(OVERFLOW),
    .ERR_CNT(ERR_CNT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Called and returns at a falling edge; the byte is sampled by the rising edge in between.
  task automatic send_byte(input logic [7:0] code, input logic err);
    RX_VALID = 1'b1;
    RX_CODE  = code;
    RX_ERR   = err;
    @(negedge CLK);
    RX_VALID = 1'b0;
    RX_ERR   = 1'b0;
  endtask

  task automatic pop_one();
    EV_READY = 1'b1;
    @(negedge CLK);
    EV_READY = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    total++; if (EV_VALID !== 1'b0) $display("FAIL reset_ev_valid: got %b want 0", EV_VALID); else passed++;
    total++; if (EV_CODE !== 8'h00) $display("FAIL reset_ev_code: got %h want 00", EV_CODE); else passed++;
    total++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", BUSY); else passed++;
    total++; if (ERR_CNT !== 8'd0) $display("FAIL reset_err_cnt: got %0d want 0", ERR_CNT); else passed++;
    total++; if (OVERFLOW !== 1'b0) $display("FAIL reset_overflow: got %b want 0", OVERFLOW); else passed++;
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_ext_break();
    EV_READY = 1'b1;
    send_byte(8'hE0, 1'b0);
    total++; if (BUSY !== 1'b1) $display("FAIL extbrk_busy_e0: got %b want 1", BUSY); else passed++;
    send_byte(8'hF0, 1'b0);
    total++; if (EV_VALID !== 1'b0) $display("FAIL extbrk_early_valid: got %b want 0", EV_VALID); else passed++;
    send_byte(8'h75, 1'b0);
    total++; if ({EV_VALID, EV_CODE, EV_EXT, EV_REL} !== {1'b1, 8'h75, 1'b1, 1'b1})
      $display("FAIL extbrk_event: got v=%b code=%h ext=%b rel=%b want v=1 code=75 ext=1 rel=1", EV_VALID, EV_CODE, EV_EXT, EV_REL);
    else passed++;
    total++; if (BUSY !== 1'b0) $display("FAIL extbrk_busy_end: got %b want 0", BUSY); else passed++;
    @(negedge CLK);
    total++; if (EV_VALID !== 1'b0) $display("FAIL extbrk_popped: got %b want 0", EV_VALID); else passed++;
    EV_READY = 1'b0;
  endtask

  task automatic test_make_break();
    send_byte(8'h1C, 1'b0);
    total++; if (BUSY !== 1'b0) $display("FAIL mkbrk_busy_make: got %b want 0", BUSY); else passed++;
    total++; if ({EV_VALID, EV_CODE, EV_EXT, EV_REL} !== {1'b1, 8'h1C, 1'b0, 1'b0})
      $display("FAIL mkbrk_make: got v=%b code=%h ext=%b rel=%b want 1 1c 0 0", EV_VALID, EV_CODE, EV_EXT, EV_REL);
    else passed++;
    send_byte(8'hF0, 1'b0);
    total++; if (BUSY !== 1'b1) $display("FAIL mkbrk_busy_f0: got %b want 1", BUSY); else passed++;
    send_byte(8'h1C, 1'b0);
    total++; if (BUSY !== 1'b0) $display("FAIL mkbrk_busy_break: got %b want 0", BUSY); else passed++;
    total++; if ({EV_CODE, EV_REL} !== {8'h1C, 1'b0}) $display("FAIL mkbrk_head_stable: got code=%h rel=%b want 1c 0", EV_CODE, EV_REL); else passed++;
    pop_one();
    total++; if ({EV_VALID, EV_CODE, EV_EXT, EV_REL} !== {1'b1, 8'h1C, 1'b0, 1'b1})
      $display("FAIL mkbrk_break: got v=%b code=%h ext=%b rel=%b want 1 1c 0 1", EV_VALID, EV_CODE, EV_EXT, EV_REL);
    else passed++;
    pop_one();
    total++; if (EV_VALID !== 1'b0) $display("FAIL mkbrk_empty: got %b want 0", EV_VALID); else passed++;
  endtask

  task automatic test_overflow();
    logic [7:0] codes [5];
    codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    for (int i = 0; i < 4; i++) send_byte(codes[i], 1'b0);
    total++; if (OVERFLOW !== 1'b0) $display("FAIL ovf_not_yet: got %b want 0", OVERFLOW); else passed++;
    send_byte(codes[4], 1'b0);
    total++; if (OVERFLOW !== 1'b1) $display("FAIL ovf_set: got %b want 1", OVERFLOW); else passed++;
    EV_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if ({EV_VALID, EV_CODE} !== {1'b1, codes[i]}) $display("FAIL ovf_drain%0d: got v=%b code=%h want 1 %h", i, EV_VALID, EV_CODE, codes[i]); else passed++;
      @(negedge CLK);
    end
    total++; if (EV_VALID !== 1'b0) $display("FAIL ovf_lost: got %b want 0", EV_VALID); else passed++;
    EV_READY = 1'b0;
    total++; if (OVERFLOW !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", OVERFLOW); else passed++;
    CLR_STATUS = 1'b1;
    @(negedge CLK);
    CLR_STATUS = 1'b0;
    total++; if (OVERFLOW !== 1'b0) $display("FAIL ovf_clear: got %b want 0", OVERFLOW); else passed++;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp [4];
    exp = '{8'h1D, 8'h24, 8'h2D, 8'h2C};
    send_byte(8'h15, 1'b0);
    send_byte(8'h1D, 1'b0);
    send_byte(8'h24, 1'b0);
    send_byte(8'h2D, 1'b0);
    EV_READY = 1'b1;
    send_byte(8'h2C, 1'b0);
    total++; if (OVERFLOW !== 1'b0) $display("FAIL fullpp_no_ovf: got %b want 0", OVERFLOW); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if ({EV_VALID, EV_CODE} !== {1'b1, exp[i]}) $display("FAIL fullpp_drain%0d: got v=%b code=%h want 1 %h", i, EV_VALID, EV_CODE, exp[i]); else passed++;
      @(negedge CLK);
    end
    total++; if (EV_VALID !== 1'b0) $display("FAIL fullpp_empty: got %b want 0", EV_VALID); else passed++;
    EV_READY = 1'b0;
  endtask

  task automatic test_timeout();
    send_byte(8'hE0, 1'b0);
    TICK = 1'b1;
    repeat (3999) @(negedge CLK);
    total++; if (BUSY !== 1'b1) $display("FAIL to_before: got %b want 1", BUSY); else passed++;
    @(negedge CLK);
    TICK = 1'b0;
    @(negedge CLK);
    total++; if (BUSY !== 1'b0) $display("FAIL to_idle: got %b want 0", BUSY); else passed++;
    total++; if (ERR_CNT !== 8'd1) $display("FAIL to_err_cnt: got %0d want 1", ERR_CNT); else passed++;
    total++; if (EV_VALID !== 1'b0) $display("FAIL to_no_event: got %b want 0", EV_VALID); else passed++;
    send_byte(8'h74, 1'b0);
    total++; if ({EV_VALID, EV_CODE, EV_EXT, EV_REL} !== {1'b1, 8'h74, 1'b0, 1'b0})
      $display("FAIL to_next_byte: got v=%b code=%h ext=%b rel=%b want 1 74 0 0", EV_VALID, EV_CODE, EV_EXT, EV_REL);
    else passed++;
    pop_one();
  endtask

  task automatic test_pause();
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 7; i++) send_byte(seq[i], 1'b0);
    total++; if ({BUSY, EV_VALID} !== 2'b10) $display("FAIL pause_mid: got busy=%b v=%b want 1 0", BUSY, EV_VALID); else passed++;
    send_byte(seq[7], 1'b0);
    total++; if ({EV_VALID, EV_CODE, EV_EXT, EV_REL, BUSY} !== {1'b1, 8'hE1, 1'b0, 1'b0, 1'b0})
      $display("FAIL pause_event: got v=%b code=%h ext=%b rel=%b busy=%b want 1 e1 0 0 0", EV_VALID, EV_CODE, EV_EXT, EV_REL, BUSY);
    else passed++;
    total++; if (ERR_CNT !== 8'd1) $display("FAIL pause_err_cnt: got %0d want 1", ERR_CNT); else passed++;
    pop_one();
    total++; if (EV_VALID !== 1'b0) $display("FAIL pause_single: got %b want 0", EV_VALID); else passed++;
  endtask

  task automatic test_rx_err_and_reset();
    CLR_STATUS = 1'b1;
    @(negedge CLK);
    CLR_STATUS = 1'b0;
    total++; if (ERR_CNT !== 8'd0) $display("FAIL rxerr_clr: got %0d want 0", ERR_CNT); else passed++;
    send_byte(8'hF0, 1'b0);
    send_byte(8'h55, 1'b1);
    total++; if ({BUSY, EV_VALID, ERR_CNT} !== {1'b0, 1'b0, 8'd1})
      $display("FAIL rxerr_abort: got busy=%b v=%b err=%0d want 0 0 1", BUSY, EV_VALID, ERR_CNT);
    else passed++;
    send_byte(8'h1C, 1'b0);
    total++; if ({EV_VALID, EV_CODE, EV_EXT, EV_REL} !== {1'b1, 8'h1C, 1'b0, 1'b0})
      $display("FAIL rxerr_next: got v=%b code=%h ext=%b rel=%b want 1 1c 0 0", EV_VALID, EV_CODE, EV_EXT, EV_REL);
    else passed++;
    pop_one();
    send_byte(8'hE0, 1'b0);
    RESET_N = 1'b0;
    #2;
    total++; if ({BUSY, ERR_CNT} !== {1'b0, 8'd0}) $display("FAIL rst_async: got busy=%b err=%0d want 0 0", BUSY, ERR_CNT); else passed++;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    send_byte(8'h6B, 1'b0);
    total++; if ({EV_VALID, EV_CODE, EV_EXT, EV_REL} !== {1'b1, 8'h6B, 1'b0, 1'b0})
      $display("FAIL rst_next: got v=%b code=%h ext=%b rel=%b want 1 6b 0 0", EV_VALID, EV_CODE, EV_EXT, EV_REL);
    else passed++;
    pop_one();
  endtask

  task automatic test_clr_race_and_sat();
    CLR_STATUS = 1'b1;
    send_byte(8'h00, 1'b0);
    CLR_STATUS = 1'b0;
    total++; if (ERR_CNT !== 8'd1) $display("FAIL clr_race_err: got %0d want 1", ERR_CNT); else passed++;
    total++; if (EV_VALID !== 1'b0) $display("FAIL clr_race_discard: got %b want 0", EV_VALID); else passed++;
    for (int i = 0; i < 260; i++) send_byte(8'hFF, 1'b0);
    total++; if (ERR_CNT !== 8'd255) $display("FAIL err_saturate: got %0d want 255", ERR_CNT); else passed++;
  endtask

  initial begin
    test_reset();
    test_ext_break();
    test_make_break();
    test_overflow();
    test_full_push_pop();
    test_timeout();
    test_pause();
    test_rx_err_and_reset();
    test_clr_race_and_sat();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
